// File: rtl/tanh_call_collector.sv
// Issues N calls to the getTanh core under a FIFO credit limit and streams the results out.
// Optional macro TANH_RANGE_CHECK_EN adds range_err_cnt, counting results with |x| > 1.0 or NaN.
module tanh_call_collector #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic              core_start,
    input  logic              core_busy,
    input  logic              core_done,
    output logic              core_stall,
    input  logic [DATA_W-1:0] core_returndata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              idle
`ifdef TANH_RANGE_CHECK_EN
    ,
    output logic [CNT_W-1:0]  range_err_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0] total_reg, issued_reg, retired_reg, popped_reg;
    logic [CNT_W-1:0] outstanding;
    logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem_q;

    logic fifo_empty, fifo_full;
    logic push, pop, load_cmd, cmd_accept, call_accept, credit_ok;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // Credit counts results in flight inside the core plus results parked in the FIFO.
    assign outstanding = issued_reg - popped_reg;
    assign credit_ok   = (outstanding < CNT_W'(FIFO_DEPTH));

    assign core_stall  = fifo_full;
    assign push        = core_done && !fifo_full && (state_reg != IDLE);
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign out_data    = fifo_empty ? '0 : mem_q[rd_ptr_reg[AW-1:0]];
    assign out_last    = out_valid && (popped_reg == total_reg - CNT_W'(1));
    assign idle        = (state_reg == IDLE) && fifo_empty;
    assign cmd_accept  = cmd_ready && cmd_valid;
    assign call_accept = core_start && !core_busy;

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        core_start = 1'b0;
        load_cmd   = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (cmd_count != '0)) begin
                    load_cmd   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                core_start = (issued_reg < total_reg) && credit_ok;
                if (issued_reg == total_reg) begin
                    state_next = DRAIN;
                end else if (call_accept && (issued_reg == total_reg - CNT_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((popped_reg == total_reg) ||
                    (pop && (popped_reg == total_reg - CNT_W'(1)))) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            total_reg   <= '0;
            issued_reg  <= '0;
            retired_reg <= '0;
            popped_reg  <= '0;
        end else if (load_cmd) begin
            total_reg   <= cmd_count;
            issued_reg  <= '0;
            retired_reg <= '0;
            popped_reg  <= '0;
        end else begin
            if (call_accept) issued_reg  <= issued_reg + CNT_W'(1);
            if (push)        retired_reg <= retired_reg + CNT_W'(1);
            if (pop)         popped_reg  <= popped_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + (AW + 1)'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(1);
        end
    end

    // Storage is not reset; out_data is forced to zero whenever the FIFO is empty.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [DATA_W-1:0] entry_reg;
            always_ff @(posedge clock) begin
                if (push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    entry_reg <= core_returndata;
                end
            end
            assign mem_q[gi] = entry_reg;
        end
    endgenerate

`ifdef TANH_RANGE_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset || cmd_accept) begin
            range_err_cnt <= '0;
        end else if (push && (core_returndata[30:0] > 31'h3F800000) &&
                     (range_err_cnt != '1)) begin
            range_err_cnt <= range_err_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_tanh_call_collector.sv
// Directed bench for tanh_call_collector: a one-cycle-latency core model plus an output monitor.
module tb_tanh_call_collector;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CNT_W-1:0]  cmd_count;
    logic              core_start;
    logic              core_busy;
    logic              core_done;
    logic              core_stall;
    logic [DATA_W-1:0] core_returndata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              idle;
`ifdef TANH_RANGE_CHECK_EN
    logic [CNT_W-1:0]  range_err_cnt;
`endif

    always #5 clock = ~clock;

    tanh_call_collector #(
        .DATA_W(DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_count(cmd_count),
        .core_start(core_start),
        .core_busy(core_busy),
        .core_done(core_done),
        .core_stall(core_stall),
        .core_returndata(core_returndata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .idle(idle)
`ifdef TANH_RANGE_CHECK_EN
        ,
        .range_err_cnt(range_err_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rdata [64];
    int          n_acc = 0;
    logic        inject_done = 1'b0;

    logic [31:0] got_data [64];
    logic        got_last [64];
    int          n_pop = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_cmd(input int n);
        cmd_valid = 1'b1;
        cmd_count = n[CNT_W-1:0];
        step(1);
        cmd_valid = 1'b0;
        cmd_count = '0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (!(cmd_ready && idle) && (k < budget)) begin
            step(1);
            k++;
        end
        check({tag, "_done"}, {31'b0, cmd_ready && idle}, 32'd1);
    endtask

    task automatic check_stream(input string tag, input int b_pop, input int b_acc, input int n);
        for (int i = 0; i < n; i++) begin
            $display("%s result %0d: data=%h last=%0b", tag, i, got_data[b_pop + i], got_last[b_pop + i]);
            check($sformatf("%s_data%0d", tag, i), got_data[b_pop + i], rdata[b_acc + i]);
            check($sformatf("%s_last%0d", tag, i), {31'b0, got_last[b_pop + i]},
                  (i == n - 1) ? 32'd1 : 32'd0);
        end
    endtask

    // Core model: returns one result the cycle after each accepted call.
    initial begin
        logic acc;
        core_done       = 1'b0;
        core_returndata = '0;
        forever begin
            @(negedge clock);
            acc = core_start && !core_busy && !reset;
            @(posedge clock);
            #1;
            if (acc) begin
                core_done       = 1'b1;
                core_returndata = rdata[n_acc];
                n_acc++;
            end else if (inject_done) begin
                core_done       = 1'b1;
                core_returndata = 32'hDEADBEEF;
            end else begin
                core_done       = 1'b0;
                core_returndata = '0;
            end
        end
    end

    // Output monitor: records every accepted result.
    initial begin
        forever begin
            @(negedge clock);
            if (out_valid && out_ready && !reset && (n_pop < 64)) begin
                got_data[n_pop] = out_data;
                got_last[n_pop] = out_last;
                n_pop++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b_acc;
        int b_pop;
        int k;

        for (int i = 0; i < 64; i++) rdata[i] = 32'h0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_count = '0;
        core_busy = 1'b0;
        out_ready = 1'b0;
        step(3);

        check("rst_cmd_ready", {31'b0, cmd_ready},  32'd1);
        check("rst_idle",      {31'b0, idle},       32'd1);
        check("rst_start",     {31'b0, core_start}, 32'd0);
        check("rst_stall",     {31'b0, core_stall}, 32'd0);
        check("rst_valid",     {31'b0, out_valid},  32'd0);
        check("rst_last",      {31'b0, out_last},   32'd0);
        check("rst_data",      out_data,            32'd0);
        reset = 1'b0;
        step(1);

        // Three calls, free-flowing output.
        b_acc = n_acc;
        b_pop = n_pop;
        rdata[b_acc + 0] = 32'h3F000000;
        rdata[b_acc + 1] = 32'hBF000000;
        rdata[b_acc + 2] = 32'h00000000;
        out_ready = 1'b1;
        send_cmd(3);
        wait_idle("t1", 50);
        check("t1_calls", n_acc - b_acc, 32'd3);
        check("t1_pops",  n_pop - b_pop, 32'd3);
        check_stream("t1", b_pop, b_acc, 3);
        check("t1_idle", {31'b0, idle}, 32'd1);

        // Eight calls with the output blocked: credit stops issue at FIFO_DEPTH.
        b_acc = n_acc;
        b_pop = n_pop;
        for (int i = 0; i < 8; i++) rdata[b_acc + i] = 32'h3E000000 + i;
        out_ready = 1'b0;
        send_cmd(8);
        step(15);
        check("t2_calls_held", n_acc - b_acc, 32'd4);
        check("t2_start_low",  {31'b0, core_start}, 32'd0);
        check("t2_stall_full", {31'b0, core_stall}, 32'd1);
        check("t2_cmd_ready",  {31'b0, cmd_ready},  32'd0);
        check("t2_valid",      {31'b0, out_valid},  32'd1);
        check("t2_head",       out_data, rdata[b_acc]);
        out_ready = 1'b1;
        wait_idle("t2", 100);
        check("t2_calls", n_acc - b_acc, 32'd8);
        check("t2_pops",  n_pop - b_pop, 32'd8);
        check_stream("t2", b_pop, b_acc, 8);

        // Core busy for five cycles: start held, nothing issued.
        b_acc = n_acc;
        b_pop = n_pop;
        rdata[b_acc + 0] = 32'h3F400000;
        rdata[b_acc + 1] = 32'hBF400000;
        core_busy = 1'b1;
        send_cmd(2);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_start_busy%0d", i), {31'b0, core_start}, 32'd1);
            step(1);
        end
        check("t3_no_issue", n_acc - b_acc, 32'd0);
        core_busy = 1'b0;
        wait_idle("t3", 50);
        check("t3_calls", n_acc - b_acc, 32'd2);
        check("t3_pops",  n_pop - b_pop, 32'd2);
        check_stream("t3", b_pop, b_acc, 2);

        // Zero-count command.
        b_acc = n_acc;
        b_pop = n_pop;
        send_cmd(0);
        check("t4_cmd_ready", {31'b0, cmd_ready},  32'd1);
        check("t4_idle",      {31'b0, idle},       32'd1);
        check("t4_start",     {31'b0, core_start}, 32'd0);
        step(5);
        check("t4_calls", n_acc - b_acc, 32'd0);
        check("t4_pops",  n_pop - b_pop, 32'd0);
        check("t4_valid", {31'b0, out_valid}, 32'd0);
        check("t4_idle2", {31'b0, idle},      32'd1);

        // Reset in the middle of a five-call command.
        b_acc = n_acc;
        out_ready = 1'b0;
        send_cmd(5);
        k = 0;
        while (((n_acc - b_acc) < 2) && (k < 20)) begin
            step(1);
            k++;
        end
        check("t5_two_issued", {31'b0, (n_acc - b_acc) >= 2}, 32'd1);
        reset = 1'b1;
        step(1);
        check("t5_cmd_ready", {31'b0, cmd_ready},  32'd1);
        check("t5_idle",      {31'b0, idle},       32'd1);
        check("t5_start",     {31'b0, core_start}, 32'd0);
        check("t5_stall",     {31'b0, core_stall}, 32'd0);
        check("t5_valid",     {31'b0, out_valid},  32'd0);
        check("t5_last",      {31'b0, out_last},   32'd0);
        check("t5_data",      out_data,            32'd0);
        reset = 1'b0;
        inject_done = 1'b1;
        step(2);
        inject_done = 1'b0;
        step(3);
        check("t5_done_ignored", {31'b0, out_valid}, 32'd0);
        check("t5_idle_after",   {31'b0, idle},      32'd1);

`ifdef TANH_RANGE_CHECK_EN
        b_acc = n_acc;
        rdata[b_acc + 0] = 32'h3F800000;
        rdata[b_acc + 1] = 32'h3F800001;
        out_ready = 1'b1;
        send_cmd(2);
        wait_idle("t6", 50);
        check("t6_range_err", {16'b0, range_err_cnt}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/tanh_call_collector.md
Name: tanh_call_collector

Overview:
- Downstream and control neighbour of the getTanh HLS component.
- Accepts a command "perform N calls", then issues N start handshakes to the core.
- Captures each returndata into an internal FIFO and streams the results out on a valid/ready interface, with the last result flagged.
- Credit-based issue ensures the core is never asked for more results than the FIFO can absorb.

Parameters:
- DATA_W, 32: width of core_returndata and out_data.
- FIFO_DEPTH, 4: result FIFO entries. Must be a power of 2 and at least 2.
- CNT_W, 16: width of the call count and internal counters.

Ports:
- clock  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_count  in  CNT_W  number of calls to perform.
- core_start  out  1  call valid to the core.
- core_busy  in  1  core call stall.
- core_done  in  1  core return valid.
- core_stall  out  1  return backpressure to the core.
- core_returndata  in  DATA_W  core result.
- out_valid  out  1  result stream valid.
- out_ready  in  1  result stream ready.
- out_data  out  DATA_W  FIFO head.
- out_last  out  1  head is the final result of the command.
- idle  out  1  FSM in IDLE and FIFO empty.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, counters=0, FIFO empty; cmd_ready=1, idle=1, core_start=0, core_stall=0, out_valid=0, out_last=0, out_data=0.
- Counters:
  - total: latched cmd_count.
  - issued: calls accepted by the core.
  - retired: results pushed into the FIFO.
  - popped: results consumed on the output.
  - All counters are CNT_W wide; none wraps because each is bounded by total.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid with cmd_count≠0: latch total, clear counters, go to RUN.
  - cmd_count=0: accepted, no calls, no output, remain IDLE.
- RUN:
  - core_start = (issued<total) && (issued−popped < FIFO_DEPTH). The credit covers results in flight plus FIFO occupancy.
  - A call is accepted when core_start && !core_busy; issued increments.
  - core_start holds steady while core_busy is high, except that it drops when the credit or count limit is reached.
  - When issued==total, go to DRAIN.
- DRAIN:
  - core_start=0.
  - When popped==total (last pop accepted), return to IDLE next cycle.
- Results:
  - core_stall = FIFO full. The credit scheme makes this unreachable in normal operation; it remains as protection.
  - Push on core_done && !core_stall; retired increments.
  - core_done while the FSM is in IDLE is ignored: no push, no error.
- Output:
  - out_valid = !empty; out_data = FIFO head, registered storage, zero-latency read of the head.
  - Pop on out_valid && out_ready; popped increments.
  - out_last = out_valid && (popped == total−1).
- Latency: a result pushed in cycle t is visible on out_valid at t+1.
- Simultaneous push and pop: both take effect and occupancy is unchanged. A push into a full FIFO while a pop occurs in the same cycle is still blocked, because core_stall is based on registered fullness.
- New commands are not accepted until the FSM returns to IDLE; cmd_ready=0 in RUN and DRAIN.
- Reset mid-operation: all state clears the next cycle. Results in flight inside the core are then dropped by the IDLE rule.

Optional Feature:
- Macro TANH_RANGE_CHECK_EN.
- Defined:
  - Extra output range_err_cnt [CNT_W].
  - Increments on each push whose float32 magnitude (bits[30:0]) > 32'h3F800000, i.e. |tanh| > 1.0 or NaN.
  - Saturates at all-ones.
  - Clears on reset and on command acceptance.
- Not defined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- cmd_count=3, core returns 32'h3F000000, 32'hBF000000, 32'h00000000, out_ready=1:
  - 3 start handshakes.
  - Outputs in order, with out_last only on 32'h00000000.
  - Back in IDLE, idle=1.
- cmd_count=8, FIFO_DEPTH=4, out_ready=0:
  - Exactly 4 calls issued, then core_start=0.
  - Raising out_ready resumes issue; 8 results delivered in order.
- cmd_count=2, core_busy held high 5 cycles:
  - core_start stays high with no issue.
  - Issues when busy drops; exactly 2 calls.
- cmd_count=0:
  - Accepted in one cycle; no core_start, no out_valid; idle stays 1.
- Reset asserted mid-RUN after 2 of 5 calls:
  - Next cycle all outputs at reset values.
  - A following core_done is ignored; out_valid stays 0.
- TANH_RANGE_CHECK_EN, results 32'h3F800000 and 32'h3F800001:
  - range_err_cnt=1.
